// File: rtl/red_pitaya_xadc_drp_arb.sv
// -----------------------------------------------------------------------------
// red_pitaya_xadc_drp_arb
//
// Shares the XADC DRP port between two requesters: sequencer readout kicked by
// end-of-conversion, and software register access. One DRP transaction runs at
// a time. A missing DRDY is caught by a timeout, so the port can never lock up.
// This block sits between the XADC primitive and the AMS register bank.
//
// Ports
//   clk_i, rst_i     DRP clock and synchronous active-high reset
//   eoc_i, chan_i    XADC end-of-conversion pulse and the channel it reports
//   sw_*_i           software request (level held until sw_ack_o), we/addr/wdata
//   sw_ack_o/err_o   one-cycle completion pulse and its timeout flag
//   sw_rdata_o       read data of the last SW access (0 for writes/timeouts)
//   meas_*_o         one-cycle new-measurement pulse with its address and DO[15:4]
//   eoc_ovr_o        pulse: an EOC that was still pending got overwritten
//   tmo_o            pulse: any transaction timed out
//   drp_*            DRP master interface towards the XADC
// -----------------------------------------------------------------------------
module red_pitaya_xadc_drp_arb #(
    parameter int unsigned TMO_CYC = 63  // WAIT cycles without DRDY before abort (1..255)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        eoc_i,
    input  logic [4:0]  chan_i,
    input  logic        sw_req_i,
    input  logic        sw_we_i,
    input  logic [6:0]  sw_addr_i,
    input  logic [15:0] sw_wdata_i,
    output logic        sw_ack_o,
    output logic        sw_err_o,
    output logic [15:0] sw_rdata_o,
    output logic        meas_vld_o,
    output logic [6:0]  meas_addr_o,
    output logic [11:0] meas_data_o,
    output logic        eoc_ovr_o,
    output logic        tmo_o,
    output logic        drp_den_o,
    output logic        drp_dwe_o,
    output logic [6:0]  drp_daddr_o,
    output logic [15:0] drp_di_o,
    input  logic [15:0] drp_do_i,
    input  logic        drp_drdy_i
);

    localparam logic [7:0] TMO_LIM = 8'(TMO_CYC);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef enum logic {
        REQ_SW  = 1'b0,
        REQ_EOC = 1'b1
    } req_t;

    state_t      state_q;
    req_t        last_q;       // requester granted most recently (fairness)
    req_t        owner_q;      // requester of the transaction in flight
    logic        eoc_pend_q;
    logic [6:0]  eoc_addr_q;
    logic [7:0]  cnt_q;

    logic        den_q;
    logic        dwe_q;
    logic [6:0]  daddr_q;
    logic [15:0] di_q;
    logic        sw_ack_q;
    logic        sw_err_q;
    logic [15:0] sw_rdata_q;
    logic        meas_vld_q;
    logic [6:0]  meas_addr_q;
    logic [11:0] meas_data_q;
    logic        eoc_ovr_q;
    logic        tmo_q;

    logic        eoc_req_d;
    logic [6:0]  eoc_addr_d;
    logic        grant_eoc_d;
    logic        grant_sw_d;
    logic [7:0]  cnt_d;

    // An EOC arriving in the same cycle counts as a request immediately, so a
    // simultaneous EOC/SW pair is arbitrated fairly instead of SW always winning.
    always_comb begin
        // NOTE: every combinational output gets a default first; a path that
        // leaves one unassigned would infer a latch.
        eoc_req_d   = eoc_pend_q | eoc_i;
        eoc_addr_d  = eoc_pend_q ? eoc_addr_q : {2'b00, chan_i};
        grant_eoc_d = 1'b0;
        grant_sw_d  = 1'b0;
        cnt_d       = cnt_q + 8'd1;
        if (state_q == ST_IDLE) begin
            if (eoc_req_d && (!sw_req_i || last_q == REQ_SW)) begin
                grant_eoc_d = 1'b1;
            end else if (sw_req_i) begin
                grant_sw_d = 1'b1;
            end
        end
    end

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            last_q      <= REQ_SW;
            owner_q     <= REQ_SW;
            eoc_pend_q  <= 1'b0;
            eoc_addr_q  <= '0;
            cnt_q       <= '0;
            den_q       <= 1'b0;
            dwe_q       <= 1'b0;
            daddr_q     <= '0;
            di_q        <= '0;
            sw_ack_q    <= 1'b0;
            sw_err_q    <= 1'b0;
            sw_rdata_q  <= '0;
            meas_vld_q  <= 1'b0;
            meas_addr_q <= '0;
            meas_data_q <= '0;
            eoc_ovr_q   <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            sw_ack_q   <= 1'b0;
            sw_err_q   <= 1'b0;
            meas_vld_q <= 1'b0;
            tmo_q      <= 1'b0;

            // Pending EOC slot. A new EOC replaces a pending one unless that
            // pending one is being granted right now. An EOC granted directly
            // in its own arrival cycle never occupies the slot.
            eoc_ovr_q <= eoc_i && eoc_pend_q && !grant_eoc_d;
            if (eoc_i) begin
                eoc_pend_q <= !(grant_eoc_d && !eoc_pend_q);
                eoc_addr_q <= {2'b00, chan_i};
            end else if (grant_eoc_d) begin
                eoc_pend_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (grant_eoc_d) begin
                        owner_q <= REQ_EOC;
                        last_q  <= REQ_EOC;
                        den_q   <= 1'b1;
                        dwe_q   <= 1'b0;
                        daddr_q <= eoc_addr_d;
                        di_q    <= '0;
                        state_q <= ST_ISSUE;
                    end else if (grant_sw_d) begin
                        owner_q <= REQ_SW;
                        last_q  <= REQ_SW;
                        den_q   <= 1'b1;
                        dwe_q   <= sw_we_i;
                        daddr_q <= sw_addr_i;
                        di_q    <= sw_wdata_i;
                        state_q <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    den_q   <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= ST_WAIT;
                end

                ST_WAIT: begin
                    // Timeout fires when this cycle would be the TMO_CYC-th WAIT
                    // cycle without DRDY; DRDY in that same cycle still succeeds.
                    if (drp_drdy_i || cnt_d == TMO_LIM) begin
                        state_q <= ST_DONE;
                        cnt_q   <= '0;
                        dwe_q   <= 1'b0;
                        daddr_q <= '0;
                        di_q    <= '0;
                        if (drp_drdy_i) begin
                            if (owner_q == REQ_SW) begin
                                sw_ack_q   <= 1'b1;
                                sw_rdata_q <= dwe_q ? 16'h0000 : drp_do_i;
                            end else begin
                                meas_vld_q  <= 1'b1;
                                meas_addr_q <= daddr_q;
                                meas_data_q <= drp_do_i[15:4];
                            end
                        end else begin
                            tmo_q <= 1'b1;
                            if (owner_q == REQ_SW) begin
                                sw_ack_q   <= 1'b1;
                                sw_err_q   <= 1'b1;
                                sw_rdata_q <= 16'h0000;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                ST_DONE: begin
                    // Single cycle for the result pulses; the SW requester
                    // drops its request here, so it cannot be re-granted.
                    state_q <= ST_IDLE;
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign sw_ack_o    = sw_ack_q;
    assign sw_err_o    = sw_err_q;
    assign sw_rdata_o  = sw_rdata_q;
    assign meas_vld_o  = meas_vld_q;
    assign meas_addr_o = meas_addr_q;
    assign meas_data_o = meas_data_q;
    assign eoc_ovr_o   = eoc_ovr_q;
    assign tmo_o       = tmo_q;
    assign drp_den_o   = den_q;
    assign drp_dwe_o   = dwe_q;
    assign drp_daddr_o = daddr_q;
    assign drp_di_o    = di_q;

endmodule
